id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Pipeline register between decode and execute in the five-stage RV32I core. It captures the decoded control word and the operands each cycle and carries them into execute. It also detects load-use hazards, inserting a bubble and stalling fetch/decode, and handles branch/jump flushes and external holds. Two saturating counters record bubbles and flushes for debug.

## Interface
Parameters:
- DATA_WIDTH, 32, width of operand, PC and immediate fields
- CNT_WIDTH, 16, width of the bubble and flush counters

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ValidD  in  1  decode slot holds a real instruction
- RegWriteD, MemWriteD, JumpD, JumpRegD, BranchD, ALUSrcD, RD1SrcD  in  1 each  decoder control
- ResultSrcD  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 imm
- ALUOpD  in  2  ALU operation class
- Funct3D  in  3  instr[14:12]
- Funct7b5D  in  1  instr[30]
- RD1D, RD2D, PCD, PCPlus4D, ImmExtD  in  DATA_WIDTH each  operands
- Rs1D, Rs2D, RdD  in  5 each  register indices
- FlushE  in  1  taken branch/jump resolved in execute
- HoldE  in  1  downstream (memory) stall; freeze this register
- All of the above with suffix E  out  same widths  registered copies, plus ValidE
- StallD  out  1  combinational; hold PC and IF/ID register
- BubbleCount, FlushCount  out  CNT_WIDTH  saturating event counters

## Operation
- LoadUseE = ValidE & (ResultSrcE == 01) & (RdE != 0) & ValidD & (RdE == Rs1D | RdE == Rs2D).
- StallD = LoadUseE & ~FlushE. A flush kills the decode slot, so no stall is needed. HoldE additionally forces StallD = 1.
- Per-edge update has the following priority:
  1. rst: all E outputs and counters go to 0.
  2. FlushE: bubble loaded.
  3. HoldE: all E registers keep their value.
  4. LoadUseE: bubble loaded.
  5. Otherwise: capture all D inputs, with ValidE = ValidD.
- Bubble:
  - ValidE = 0.
  - RegWriteE, MemWriteE, JumpE, JumpRegE and BranchE are 0.
  - ResultSrcE = 00, ALUOpE = 00, ALUSrcE = 0, RD1SrcE = 0.
  - Data and index fields are 0.
- When ValidD = 0 and the register captures, all side-effecting controls (RegWrite, MemWrite, Jump, JumpReg, Branch) are forced to 0. A bubble is never architecturally visible.
- BubbleCount increments on every edge that loads a load-use bubble. FlushCount increments on every edge taking the FlushE path. Both saturate at all-ones and never wrap.
- FlushE and HoldE together: the flush wins and the bubble is loaded.

## Timing
- Capture latency is 1 cycle: D values present before edge n appear on E outputs after edge n.
- StallD is combinational from E registers and D inputs, valid in the same cycle. There is no registered delay.
- Load-use penalty is exactly one bubble:
  - Cycle n: the load is in E and the dependent instruction is in D, so StallD = 1.
  - Edge n: the bubble enters E.
  - Cycle n+1: LoadUseE = 0, because E now holds the bubble. The dependent instruction proceeds at edge n+1.
- Reset is asynchronous: outputs clear immediately on rst rising, independent of clk, including mid-stall. The first capture happens at the first edge after rst falls.
- Held registers stay stable for any number of HoldE cycles. Counters do not change while held.

## Test plan
- Reset mid-stream: load pipeline with RegWriteD=1, RdD=5, then assert rst between edges -> all E outputs and counters read 0 immediately. StallD = 0.
- Plain capture: ValidD=1, RegWriteD=1, ALUOpD=10, RD1D=0x1234, RdD=7 -> one edge later RegWriteE=1, ALUOpE=10, RD1E=0x1234, RdE=7, ValidE=1.
- Load-use: lw x5 in E (ResultSrcE=01, RdE=5), add with Rs1D=5 -> StallD=1, next edge ValidE=0 with all controls 0, BubbleCount=1. Following edge captures the add. Repeat with RdE=0 -> StallD=0, no bubble.
- Flush vs hold: FlushE=1 and HoldE=1 together, with a valid store in D -> next edge MemWriteE=0, ValidE=0, FlushCount=1. Then HoldE=1 alone for 3 cycles -> E outputs unchanged, counters unchanged.
- Invalid slot: ValidD=0, MemWriteD=1, JumpD=1 -> after the edge ValidE=0, MemWriteE=0, JumpE=0.
- Saturation: CNT_WIDTH=2, force 5 load-use bubbles -> BubbleCount reads 3 and stays there.

Source files
------------

// File: rtl/id_ex_if.sv
// Decode-to-execute bundle: decode-side fields and controls in, execute-side copies,
// stall request and debug counters out.
interface id_ex_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  ValidD, RegWriteD, MemWriteD, JumpD, JumpRegD, BranchD, ALUSrcD, RD1SrcD;
    logic [1:0]            ResultSrcD, ALUOpD;
    logic [2:0]            Funct3D;
    logic                  Funct7b5D;
    logic [DATA_WIDTH-1:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
    logic [4:0]            Rs1D, Rs2D, RdD;
    logic                  FlushE, HoldE;

    logic                  ValidE, RegWriteE, MemWriteE, JumpE, JumpRegE, BranchE, ALUSrcE, RD1SrcE;
    logic [1:0]            ResultSrcE, ALUOpE;
    logic [2:0]            Funct3E;
    logic                  Funct7b5E;
    logic [DATA_WIDTH-1:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
    logic [4:0]            Rs1E, Rs2E, RdE;
    logic                  StallD;
    logic [CNT_WIDTH-1:0]  BubbleCount, FlushCount;

    modport master (
        output ValidD, RegWriteD, MemWriteD, JumpD, JumpRegD, BranchD, ALUSrcD, RD1SrcD,
               ResultSrcD, ALUOpD, Funct3D, Funct7b5D, RD1D, RD2D, PCD, PCPlus4D, ImmExtD,
               Rs1D, Rs2D, RdD, FlushE, HoldE,
        input  ValidE, RegWriteE, MemWriteE, JumpE, JumpRegE, BranchE, ALUSrcE, RD1SrcE,
               ResultSrcE, ALUOpE, Funct3E, Funct7b5E, RD1E, RD2E, PCE, PCPlus4E, ImmExtE,
               Rs1E, Rs2E, RdE, StallD, BubbleCount, FlushCount
    );

    modport slave (
        input  ValidD, RegWriteD, MemWriteD, JumpD, JumpRegD, BranchD, ALUSrcD, RD1SrcD,
               ResultSrcD, ALUOpD, Funct3D, Funct7b5D, RD1D, RD2D, PCD, PCPlus4D, ImmExtD,
               Rs1D, Rs2D, RdD, FlushE, HoldE,
        output ValidE, RegWriteE, MemWriteE, JumpE, JumpRegE, BranchE, ALUSrcE, RD1SrcE,
               ResultSrcE, ALUOpE, Funct3E, Funct7b5E, RD1E, RD2E, PCE, PCPlus4E, ImmExtE,
               Rs1E, Rs2E, RdE, StallD, BubbleCount, FlushCount
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the five-stage RV32I core: captures the decoded word,
// inserts load-use bubbles, obeys execute flushes and downstream holds, counts events.
module id_ex_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic   clk,
    input  logic   rst,
    id_ex_if.slave io_bus
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  mem_write;
        logic                  jump;
        logic                  jump_reg;
        logic                  branch;
        logic                  alu_src;
        logic                  rd1_src;
        logic [1:0]            result_src;
        logic [1:0]            alu_op;
        logic [2:0]            funct3;
        logic                  funct7b5;
        logic [DATA_WIDTH-1:0] rd1;
        logic [DATA_WIDTH-1:0] rd2;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] pc_plus4;
        logic [DATA_WIDTH-1:0] imm;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [4:0]            rd;
    } ex_word_t;

    ex_word_t             r_ex;
    ex_word_t             w_cap;
    logic                 w_load_use;
    logic [CNT_WIDTH-1:0] r_bubble_cnt;
    logic [CNT_WIDTH-1:0] r_flush_cnt;

    // A load in E whose destination feeds the instruction in D needs one bubble.
    assign w_load_use = r_ex.valid & (r_ex.result_src == 2'b01) & (r_ex.rd != 5'd0) &
                        io_bus.ValidD & ((r_ex.rd == io_bus.Rs1D) | (r_ex.rd == io_bus.Rs2D));

    // Capture word; an empty decode slot must not carry any side-effecting control.
    always_comb begin
        w_cap            = '0;
        w_cap.valid      = io_bus.ValidD;
        w_cap.reg_write  = io_bus.RegWriteD & io_bus.ValidD;
        w_cap.mem_write  = io_bus.MemWriteD & io_bus.ValidD;
        w_cap.jump       = io_bus.JumpD     & io_bus.ValidD;
        w_cap.jump_reg   = io_bus.JumpRegD  & io_bus.ValidD;
        w_cap.branch     = io_bus.BranchD   & io_bus.ValidD;
        w_cap.alu_src    = io_bus.ALUSrcD;
        w_cap.rd1_src    = io_bus.RD1SrcD;
        w_cap.result_src = io_bus.ResultSrcD;
        w_cap.alu_op     = io_bus.ALUOpD;
        w_cap.funct3     = io_bus.Funct3D;
        w_cap.funct7b5   = io_bus.Funct7b5D;
        w_cap.rd1        = io_bus.RD1D;
        w_cap.rd2        = io_bus.RD2D;
        w_cap.pc         = io_bus.PCD;
        w_cap.pc_plus4   = io_bus.PCPlus4D;
        w_cap.imm        = io_bus.ImmExtD;
        w_cap.rs1        = io_bus.Rs1D;
        w_cap.rs2        = io_bus.Rs2D;
        w_cap.rd         = io_bus.RdD;
    end

    // Pipeline register and event counters; flush outranks hold, hold outranks load-use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex         <= '0;
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else if (io_bus.FlushE) begin
            r_ex <= '0;
            if (r_flush_cnt != CNT_MAX) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end else if (io_bus.HoldE) begin
            r_ex <= r_ex;
        end else if (w_load_use) begin
            r_ex <= '0;
            if (r_bubble_cnt != CNT_MAX) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
            end
        end else begin
            r_ex <= w_cap;
        end
    end

    assign io_bus.StallD      = (w_load_use & ~io_bus.FlushE) | io_bus.HoldE;
    assign io_bus.ValidE      = r_ex.valid;
    assign io_bus.RegWriteE   = r_ex.reg_write;
    assign io_bus.MemWriteE   = r_ex.mem_write;
    assign io_bus.JumpE       = r_ex.jump;
    assign io_bus.JumpRegE    = r_ex.jump_reg;
    assign io_bus.BranchE     = r_ex.branch;
    assign io_bus.ALUSrcE     = r_ex.alu_src;
    assign io_bus.RD1SrcE     = r_ex.rd1_src;
    assign io_bus.ResultSrcE  = r_ex.result_src;
    assign io_bus.ALUOpE      = r_ex.alu_op;
    assign io_bus.Funct3E     = r_ex.funct3;
    assign io_bus.Funct7b5E   = r_ex.funct7b5;
    assign io_bus.RD1E        = r_ex.rd1;
    assign io_bus.RD2E        = r_ex.rd2;
    assign io_bus.PCE         = r_ex.pc;
    assign io_bus.PCPlus4E    = r_ex.pc_plus4;
    assign io_bus.ImmExtE     = r_ex.imm;
    assign io_bus.Rs1E        = r_ex.rs1;
    assign io_bus.Rs2E        = r_ex.rs2;
    assign io_bus.RdE         = r_ex.rd;
    assign io_bus.BubbleCount = r_bubble_cnt;
    assign io_bus.FlushCount  = r_flush_cnt;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; counters are narrowed to 2 bits so saturation is reachable.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    id_ex_if #(.DATA_WIDTH(32), .CNT_WIDTH(2)) bus ();
    id_ex_stage #(.DATA_WIDTH(32), .CNT_WIDTH(2)) dut (.clk(clk), .rst(rst), .io_bus(bus));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_d();
        bus.ValidD = 1'b0; bus.RegWriteD = 1'b0; bus.MemWriteD = 1'b0; bus.JumpD = 1'b0;
        bus.JumpRegD = 1'b0; bus.BranchD = 1'b0; bus.ALUSrcD = 1'b0; bus.RD1SrcD = 1'b0;
        bus.ResultSrcD = 2'b00; bus.ALUOpD = 2'b00; bus.Funct3D = 3'd0; bus.Funct7b5D = 1'b0;
        bus.RD1D = 32'd0; bus.RD2D = 32'd0; bus.PCD = 32'd0; bus.PCPlus4D = 32'd0; bus.ImmExtD = 32'd0;
        bus.Rs1D = 5'd0; bus.Rs2D = 5'd0; bus.RdD = 5'd0; bus.FlushE = 1'b0; bus.HoldE = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        clear_d();
    endtask

    task automatic load_lw(input logic [4:0] rd);
        clear_d();
        bus.ValidD = 1'b1; bus.RegWriteD = 1'b1; bus.ResultSrcD = 2'b01; bus.ALUSrcD = 1'b1;
        bus.Funct3D = 3'b010; bus.RdD = rd;
    endtask

    task automatic load_add(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        clear_d();
        bus.ValidD = 1'b1; bus.RegWriteD = 1'b1; bus.ALUOpD = 2'b10;
        bus.Rs1D = rs1; bus.Rs2D = rs2; bus.RdD = rd;
    endtask

    task automatic test_reset();
        clear_d();
        repeat (2) step();
        rst = 1'b0;
        load_lw(5'd5);
        step();
        load_add(5'd5, 5'd0, 5'd9);
        #1;
        n_chk++; if (bus.StallD !== 1'b1) begin n_err++; $display("FAIL rst_pre_stall: got %0h want 1", bus.StallD); end
        n_chk++; if (bus.RdE !== 5'd5) begin n_err++; $display("FAIL rst_pre_rd: got %0d want 5", bus.RdE); end
        #2;
        rst = 1'b1;
        #1;
        n_chk++; if (bus.ValidE !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0h want 0", bus.ValidE); end
        n_chk++; if (bus.RegWriteE !== 1'b0) begin n_err++; $display("FAIL rst_regwrite: got %0h want 0", bus.RegWriteE); end
        n_chk++; if (bus.RdE !== 5'd0) begin n_err++; $display("FAIL rst_rd: got %0d want 0", bus.RdE); end
        n_chk++; if (bus.ResultSrcE !== 2'b00) begin n_err++; $display("FAIL rst_resultsrc: got %0h want 0", bus.ResultSrcE); end
        n_chk++; if (bus.BubbleCount !== 2'd0 || bus.FlushCount !== 2'd0) begin
            n_err++; $display("FAIL rst_counters: got %0d/%0d want 0/0", bus.BubbleCount, bus.FlushCount); end
        n_chk++; if (bus.StallD !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %0h want 0", bus.StallD); end
        #1;
        rst = 1'b0;
        clear_d();
    endtask

    task automatic test_capture();
        clear_d();
        bus.ValidD = 1'b1; bus.RegWriteD = 1'b1; bus.ALUOpD = 2'b10; bus.RD1D = 32'h0000_1234; bus.RdD = 5'd7;
        bus.RD2D = 32'hCAFE_0001; bus.PCD = 32'h0000_0040; bus.Funct3D = 3'b110;
        step();
        n_chk++; if (bus.RegWriteE !== 1'b1) begin n_err++; $display("FAIL cap_regwrite: got %0h want 1", bus.RegWriteE); end
        n_chk++; if (bus.ALUOpE !== 2'b10) begin n_err++; $display("FAIL cap_aluop: got %0h want 2", bus.ALUOpE); end
        n_chk++; if (bus.RD1E !== 32'h0000_1234) begin n_err++; $display("FAIL cap_rd1: got %h want 00001234", bus.RD1E); end
        n_chk++; if (bus.RD2E !== 32'hCAFE_0001) begin n_err++; $display("FAIL cap_rd2: got %h want cafe0001", bus.RD2E); end
        n_chk++; if (bus.PCE !== 32'h0000_0040) begin n_err++; $display("FAIL cap_pc: got %h want 00000040", bus.PCE); end
        n_chk++; if (bus.Funct3E !== 3'b110) begin n_err++; $display("FAIL cap_funct3: got %0h want 6", bus.Funct3E); end
        n_chk++; if (bus.RdE !== 5'd7) begin n_err++; $display("FAIL cap_rd: got %0d want 7", bus.RdE); end
        n_chk++; if (bus.ValidE !== 1'b1) begin n_err++; $display("FAIL cap_valid: got %0h want 1", bus.ValidE); end
    endtask

    task automatic test_load_use();
        do_reset();
        load_lw(5'd5);
        step();
        load_add(5'd5, 5'd6, 5'd8);
        #1;
        n_chk++; if (bus.StallD !== 1'b1) begin n_err++; $display("FAIL lu_stall: got %0h want 1", bus.StallD); end
        step();
        n_chk++; if (bus.ValidE !== 1'b0 || bus.RegWriteE !== 1'b0 || bus.ResultSrcE !== 2'b00 ||
                     bus.ALUOpE !== 2'b00 || bus.ALUSrcE !== 1'b0 || bus.RdE !== 5'd0) begin
            n_err++; $display("FAIL lu_bubble: got v%0h rw%0h rs%0h op%0h as%0h rd%0d want all 0",
                bus.ValidE, bus.RegWriteE, bus.ResultSrcE, bus.ALUOpE, bus.ALUSrcE, bus.RdE); end
        n_chk++; if (bus.BubbleCount !== 2'd1) begin n_err++; $display("FAIL lu_count: got %0d want 1", bus.BubbleCount); end
        n_chk++; if (bus.StallD !== 1'b0) begin n_err++; $display("FAIL lu_stall_after: got %0h want 0", bus.StallD); end
        step();
        n_chk++; if (bus.ValidE !== 1'b1 || bus.RdE !== 5'd8 || bus.Rs1E !== 5'd5) begin
            n_err++; $display("FAIL lu_proceed: got v%0h rd%0d rs1%0d want v1 rd8 rs1 5", bus.ValidE, bus.RdE, bus.Rs1E); end
        // Match on rs2 also stalls.
        load_lw(5'd6);
        step();
        load_add(5'd1, 5'd6, 5'd2);
        #1;
        n_chk++; if (bus.StallD !== 1'b1) begin n_err++; $display("FAIL lu_rs2_stall: got %0h want 1", bus.StallD); end
        step();
        n_chk++; if (bus.BubbleCount !== 2'd2) begin n_err++; $display("FAIL lu_rs2_count: got %0d want 2", bus.BubbleCount); end
        step();
        // Load to x0 never creates a hazard.
        load_lw(5'd0);
        step();
        load_add(5'd0, 5'd0, 5'd8);
        #1;
        n_chk++; if (bus.StallD !== 1'b0) begin n_err++; $display("FAIL lu_x0_stall: got %0h want 0", bus.StallD); end
        step();
        n_chk++; if (bus.ValidE !== 1'b1 || bus.RdE !== 5'd8 || bus.BubbleCount !== 2'd2) begin
            n_err++; $display("FAIL lu_x0_capture: got v%0h rd%0d cnt%0d want v1 rd8 cnt2", bus.ValidE, bus.RdE, bus.BubbleCount); end
        // Invalid decode slot does not stall.
        load_lw(5'd4);
        step();
        load_add(5'd4, 5'd0, 5'd3);
        bus.ValidD = 1'b0;
        #1;
        n_chk++; if (bus.StallD !== 1'b0) begin n_err++; $display("FAIL lu_invalid_d: got %0h want 0", bus.StallD); end
    endtask

    task automatic test_flush_hold();
        do_reset();
        load_add(5'd1, 5'd2, 5'd3);
        step();
        clear_d();
        bus.ValidD = 1'b1; bus.MemWriteD = 1'b1; bus.ALUSrcD = 1'b1; bus.Rs1D = 5'd1; bus.Rs2D = 5'd2;
        bus.FlushE = 1'b1; bus.HoldE = 1'b1;
        #1;
        n_chk++; if (bus.StallD !== 1'b1) begin n_err++; $display("FAIL fh_stall: got %0h want 1", bus.StallD); end
        step();
        n_chk++; if (bus.MemWriteE !== 1'b0 || bus.ValidE !== 1'b0 || bus.RdE !== 5'd0) begin
            n_err++; $display("FAIL fh_bubble: got mw%0h v%0h rd%0d want 0 0 0", bus.MemWriteE, bus.ValidE, bus.RdE); end
        n_chk++; if (bus.FlushCount !== 2'd1) begin n_err++; $display("FAIL fh_flushcnt: got %0d want 1", bus.FlushCount); end
        bus.FlushE = 1'b0; bus.HoldE = 1'b0;
        step();
        n_chk++; if (bus.MemWriteE !== 1'b1 || bus.Rs2E !== 5'd2) begin
            n_err++; $display("FAIL fh_store: got mw%0h rs2 %0d want 1 2", bus.MemWriteE, bus.Rs2E); end
        load_add(5'd9, 5'd10, 5'd11);
        bus.HoldE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++; if (bus.MemWriteE !== 1'b1 || bus.ValidE !== 1'b1 || bus.Rs2E !== 5'd2 ||
                         bus.RdE !== 5'd0 || bus.RegWriteE !== 1'b0) begin
                n_err++; $display("FAIL hold_keep%0d: got mw%0h v%0h rs2 %0d rd%0d rw%0h want 1 1 2 0 0",
                    i, bus.MemWriteE, bus.ValidE, bus.Rs2E, bus.RdE, bus.RegWriteE); end
            n_chk++; if (bus.FlushCount !== 2'd1 || bus.BubbleCount !== 2'd0) begin
                n_err++; $display("FAIL hold_cnt%0d: got %0d/%0d want 1/0", i, bus.FlushCount, bus.BubbleCount); end
        end
        n_chk++; if (bus.StallD !== 1'b1) begin n_err++; $display("FAIL hold_stall: got %0h want 1", bus.StallD); end
        bus.HoldE = 1'b0;
        step();
        n_chk++; if (bus.RdE !== 5'd11 || bus.RegWriteE !== 1'b1) begin
            n_err++; $display("FAIL hold_release: got rd%0d rw%0h want 11 1", bus.RdE, bus.RegWriteE); end
    endtask

    task automatic test_invalid();
        clear_d();
        bus.ValidD = 1'b0; bus.MemWriteD = 1'b1; bus.JumpD = 1'b1; bus.RegWriteD = 1'b1;
        bus.BranchD = 1'b1; bus.JumpRegD = 1'b1;
        step();
        n_chk++; if (bus.ValidE !== 1'b0 || bus.MemWriteE !== 1'b0 || bus.JumpE !== 1'b0) begin
            n_err++; $display("FAIL inv_main: got v%0h mw%0h j%0h want 0 0 0", bus.ValidE, bus.MemWriteE, bus.JumpE); end
        n_chk++; if (bus.RegWriteE !== 1'b0 || bus.BranchE !== 1'b0 || bus.JumpRegE !== 1'b0) begin
            n_err++; $display("FAIL inv_other: got rw%0h br%0h jr%0h want 0 0 0", bus.RegWriteE, bus.BranchE, bus.JumpRegE); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            load_lw(5'd5);
            step();
            load_add(5'd5, 5'd0, 5'd1);
            step();
            n_chk++; if (bus.BubbleCount !== ((i >= 2) ? 2'd3 : 2'(i + 1))) begin
                n_err++; $display("FAIL sat_bubble%0d: got %0d want %0d", i, bus.BubbleCount, (i >= 2) ? 3 : i + 1); end
        end
        for (int i = 0; i < 4; i++) begin
            bus.FlushE = 1'b1;
            step();
        end
        bus.FlushE = 1'b0;
        n_chk++; if (bus.FlushCount !== 2'd3) begin n_err++; $display("FAIL sat_flush: got %0d want 3", bus.FlushCount); end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_load_use();
        test_flush_hold();
        test_invalid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
